eth_recv_udp: RTL and testbench

//  Receive-side consumer of the 10G MAC's 64-bit AXI-Stream rx output (m_axis_rx_*) in the clk156 domain.

---
 rtl/eth_recv_udp.sv | 200 ++++++++++++++++++++
 tb/tb_eth_recv_udp.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_recv_udp.sv
// eth_recv_udp: receive-side UDP filter for the 10G MAC rx stream (clk156 domain).
// Parses the Ethernet/IPv4/UDP header over the first six beats, drops every
// frame not addressed to this node, strips the 42-byte header and re-aligns
// the UDP payload so the first payload byte lands in byte 0 of the output.
// Ports:
//   clk156, reset           : core clock, synchronous active-high reset
//   s_axis_rx_*             : MAC rx stream (no back-pressure)
//   m_axis_*                : re-aligned UDP payload stream (no back-pressure)
//   cnt_rx_frame/accept/drop: wrapping frame statistics
module eth_recv_udp #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A35000001,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80A01,
    parameter logic [15:0] LOCAL_PORT = 16'd3776
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic        s_axis_rx_tvalid,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [31:0] cnt_rx_frame,
    output logic [31:0] cnt_rx_accept,
    output logic [31:0] cnt_rx_drop
);

    localparam int unsigned BEAT_W   = 3;
    localparam int unsigned CARRY_W  = 48;
    localparam int unsigned CKEEP_W  = 6;
    localparam logic [BEAT_W-1:0] LAST_HDR_BEAT = BEAT_W'(5);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t               state;
    logic [BEAT_W-1:0]    beat_idx;
    logic                 match;
    logic [CARRY_W-1:0]   carry;
    logic [CKEEP_W-1:0]   carry_keep;
    logic                 flush_pend;
    logic                 flush_user;

    logic [47:0]          dst_mac_c;
    logic                 hdr_ok_c;

    // Header fields are big-endian on the wire: byte 0 is the MAC MSB.
    assign dst_mac_c = {s_axis_rx_tdata[7:0],   s_axis_rx_tdata[15:8],
                        s_axis_rx_tdata[23:16], s_axis_rx_tdata[31:24],
                        s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};

    // Per-beat header field check for the current header beat.
    always_comb begin
        hdr_ok_c = 1'b1;
        case (beat_idx)
            BEAT_W'(0): hdr_ok_c = (dst_mac_c == LOCAL_MAC) ||
                                   (dst_mac_c == 48'hFFFF_FFFF_FFFF);
            BEAT_W'(1): hdr_ok_c = ({s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]} == 16'h0800) &&
                                   (s_axis_rx_tdata[55:48] == 8'h45);
            BEAT_W'(2): hdr_ok_c = (s_axis_rx_tdata[63:56] == 8'h11);
            BEAT_W'(3): hdr_ok_c = ({s_axis_rx_tdata[55:48], s_axis_rx_tdata[63:56]} == LOCAL_IP[31:16]);
            BEAT_W'(4): hdr_ok_c = ({s_axis_rx_tdata[7:0], s_axis_rx_tdata[15:8]} == LOCAL_IP[15:0]) &&
                                   ({s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]} == LOCAL_PORT);
            default:    hdr_ok_c = 1'b1;
        endcase
    end

    // Parser FSM, payload re-alignment and statistics.
    always_ff @(posedge clk156) begin
        if (reset) begin
            state         <= SYNC;
            beat_idx      <= '0;
            match         <= 1'b0;
            carry         <= '0;
            carry_keep    <= '0;
            flush_pend    <= 1'b0;
            flush_user    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            cnt_rx_frame  <= '0;
            cnt_rx_accept <= '0;
            cnt_rx_drop   <= '0;
        end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            flush_pend    <= 1'b0;

            // Trailing bytes of the previous frame; the input at most carries
            // a new beat 0 now, which never produces output.
            if (flush_pend) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= {16'h0, carry};
                m_axis_tkeep  <= {2'b00, carry_keep};
                m_axis_tlast  <= 1'b1;
                m_axis_tuser  <= flush_user;
            end

            if (s_axis_rx_tvalid) begin
                case (state)
                    // Skip the remainder of a frame cut by reset.
                    SYNC: begin
                        if (s_axis_rx_tlast) begin
                            state    <= HDR;
                            beat_idx <= '0;
                        end
                    end

                    HDR: begin
                        match <= (beat_idx == '0) ? hdr_ok_c : (match & hdr_ok_c);
                        if (beat_idx == LAST_HDR_BEAT) begin
                            carry      <= s_axis_rx_tdata[63:16];
                            carry_keep <= s_axis_rx_tkeep[7:2];
                            beat_idx   <= '0;
                            if (s_axis_rx_tlast) begin
                                // Payload fits entirely in this beat.
                                cnt_rx_frame <= cnt_rx_frame + 32'd1;
                                if (match && s_axis_rx_tuser) begin
                                    cnt_rx_accept <= cnt_rx_accept + 32'd1;
                                end else begin
                                    cnt_rx_drop <= cnt_rx_drop + 32'd1;
                                end
                                if (match && (s_axis_rx_tkeep[7:2] != '0)) begin
                                    flush_pend <= 1'b1;
                                    flush_user <= s_axis_rx_tuser;
                                end
                                state <= HDR;
                            end else begin
                                state <= match ? PAYLOAD : DROP;
                            end
                        end else if (s_axis_rx_tlast) begin
                            // Truncated header.
                            cnt_rx_frame <= cnt_rx_frame + 32'd1;
                            cnt_rx_drop  <= cnt_rx_drop + 32'd1;
                            beat_idx     <= '0;
                        end else begin
                            beat_idx <= beat_idx + BEAT_W'(1);
                        end
                    end

                    PAYLOAD: begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {s_axis_rx_tdata[15:0], carry};
                        m_axis_tkeep  <= {s_axis_rx_tkeep[1:0], carry_keep};
                        carry         <= s_axis_rx_tdata[63:16];
                        carry_keep    <= s_axis_rx_tkeep[7:2];
                        if (s_axis_rx_tlast) begin
                            cnt_rx_frame <= cnt_rx_frame + 32'd1;
                            if (s_axis_rx_tuser) begin
                                cnt_rx_accept <= cnt_rx_accept + 32'd1;
                            end else begin
                                cnt_rx_drop <= cnt_rx_drop + 32'd1;
                            end
                            // Bytes 2+ of the last beat spill into a flush beat.
                            if (s_axis_rx_tkeep[2]) begin
                                flush_pend <= 1'b1;
                                flush_user <= s_axis_rx_tuser;
                            end else begin
                                m_axis_tlast <= 1'b1;
                                m_axis_tuser <= s_axis_rx_tuser;
                            end
                            state    <= HDR;
                            beat_idx <= '0;
                        end
                    end

                    DROP: begin
                        if (s_axis_rx_tlast) begin
                            cnt_rx_frame <= cnt_rx_frame + 32'd1;
                            cnt_rx_drop  <= cnt_rx_drop + 32'd1;
                            state        <= HDR;
                            beat_idx     <= '0;
                        end
                    end

                    default: begin
                        state    <= SYNC;
                        beat_idx <= '0;
                    end
                endcase
            end else if (state == SYNC) begin
                // An idle cycle marks a frame boundary.
                state    <= HDR;
                beat_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_eth_recv_udp.sv
// tb_eth_recv_udp: directed and randomized frames against a byte-level
// reference model of the UDP filter (payload = frame bytes 42.. when the
// addressed fields match), with a scoreboard on the output stream.
module tb_eth_recv_udp;

    localparam logic [47:0] LOCAL_MAC  = 48'h000A35000001;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A80A01;
    localparam logic [15:0] LOCAL_PORT = 16'd3776;
    localparam logic [47:0] BCAST      = 48'hFFFFFFFFFFFF;

    logic        clk156 = 1'b0;
    logic        reset;
    logic        s_axis_rx_tvalid;
    logic [63:0] s_axis_rx_tdata;
    logic [7:0]  s_axis_rx_tkeep;
    logic        s_axis_rx_tlast;
    logic        s_axis_rx_tuser;
    logic        m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [31:0] cnt_rx_frame;
    logic [31:0] cnt_rx_accept;
    logic [31:0] cnt_rx_drop;

    eth_recv_udp #(
        .LOCAL_MAC (LOCAL_MAC),
        .LOCAL_IP  (LOCAL_IP),
        .LOCAL_PORT(LOCAL_PORT)
    ) dut (
        .clk156          (clk156),
        .reset           (reset),
        .s_axis_rx_tvalid(s_axis_rx_tvalid),
        .s_axis_rx_tdata (s_axis_rx_tdata),
        .s_axis_rx_tkeep (s_axis_rx_tkeep),
        .s_axis_rx_tlast (s_axis_rx_tlast),
        .s_axis_rx_tuser (s_axis_rx_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .cnt_rx_frame    (cnt_rx_frame),
        .cnt_rx_accept   (cnt_rx_accept),
        .cnt_rx_drop     (cnt_rx_drop)
    );

    always #3 clk156 = ~clk156;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } exp_beat_t;

    exp_beat_t   exp_q[$];
    logic [7:0]  fr[$];
    int          errors = 0;
    int          checks = 0;
    int          beats_seen = 0;
    int unsigned m_frame = 0, m_accept = 0, m_drop = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Build a UDP/IPv4/Ethernet frame (without FCS) into fr.
    task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                         input logic [7:0] vihl, input logic [7:0] proto,
                         input logic [31:0] dip, input logic [15:0] dport,
                         input int plen, input bit incr);
        logic [47:0] smac;
        logic [31:0] sip;
        logic [15:0] iplen;
        logic [15:0] udplen;
        smac   = 48'h021122334455;
        sip    = 32'hC0A80A02;
        iplen  = 16'(28 + plen);
        udplen = 16'(8 + plen);
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(dmac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(smac[47-8*i -: 8]);
        fr.push_back(etype[15:8]);  fr.push_back(etype[7:0]);
        fr.push_back(vihl);         fr.push_back(8'h00);
        fr.push_back(iplen[15:8]);  fr.push_back(iplen[7:0]);
        fr.push_back(8'h12);        fr.push_back(8'h34);
        fr.push_back(8'h40);        fr.push_back(8'h00);
        fr.push_back(8'h40);        fr.push_back(proto);
        fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) fr.push_back(sip[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) fr.push_back(dip[31-8*i -: 8]);
        fr.push_back(8'h9C);        fr.push_back(8'h40);
        fr.push_back(dport[15:8]);  fr.push_back(dport[7:0]);
        fr.push_back(udplen[15:8]); fr.push_back(udplen[7:0]);
        fr.push_back(8'h00);        fr.push_back(8'h00);
        for (int i = 0; i < plen; i++) fr.push_back(incr ? 8'(i) : 8'($urandom));
    endtask

    // Reference: decide from frame bytes, queue expected payload beats, count.
    task automatic model_frame(input bit user);
        int n;
        int p;
        bit match;
        exp_beat_t e;
        n = fr.size();
        match = 1'b0;
        if (n >= 41) begin
            match = ({fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]} == LOCAL_MAC ||
                     {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]} == BCAST) &&
                    ({fr[12], fr[13]} == 16'h0800) && (fr[14] == 8'h45) &&
                    (fr[23] == 8'h11) &&
                    ({fr[30], fr[31], fr[32], fr[33]} == LOCAL_IP) &&
                    ({fr[36], fr[37]} == LOCAL_PORT);
        end
        m_frame++;
        if (match && user) m_accept++;
        else               m_drop++;
        if (match) begin
            p = n - 42;
            for (int off = 0; off < p; off += 8) begin
                e = '0;
                for (int j = 0; j < 8; j++) begin
                    if (off + j < p) begin
                        e.data[8*j +: 8] = fr[42 + off + j];
                        e.keep[j] = 1'b1;
                    end
                end
                e.last = (off + 8 >= p);
                e.user = e.last ? user : 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk156);
            s_axis_rx_tvalid = 1'b0;
            s_axis_rx_tdata  = {$urandom, $urandom};
            s_axis_rx_tkeep  = 8'($urandom);
            s_axis_rx_tlast  = 1'($urandom);
            s_axis_rx_tuser  = 1'($urandom);
        end
    endtask

    // Drive fr as one frame; gap_pct inserts tvalid gaps, rst_beat>=0 resets there.
    task automatic send(input bit user, input int gap_pct, input int rst_beat);
        int n;
        int nb;
        n  = fr.size();
        nb = (n + 7) / 8;
        if (rst_beat < 0) model_frame(user);
        for (int b = 0; b < nb; b++) begin
            while (gap_pct > 0 && b > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
            @(negedge clk156);
            s_axis_rx_tvalid = 1'b1;
            reset = (b == rst_beat);
            if (b == rst_beat) begin
                exp_q.delete();
                m_frame = 0; m_accept = 0; m_drop = 0;
            end
            for (int j = 0; j < 8; j++) begin
                s_axis_rx_tdata[8*j +: 8] = (8*b + j < n) ? fr[8*b + j] : 8'($urandom);
                s_axis_rx_tkeep[j]        = (8*b + j < n);
            end
            s_axis_rx_tlast = (b == nb - 1);
            s_axis_rx_tuser = (b == nb - 1) ? user : 1'($urandom);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_frame"},  cnt_rx_frame,  64'(m_frame));
        chk({tag, "_accept"}, cnt_rx_accept, 64'(m_accept));
        chk({tag, "_drop"},   cnt_rx_drop,   64'(m_drop));
    endtask

    task automatic good_frame(input int plen, input bit incr);
        build(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, plen, incr);
    endtask

    // Output scoreboard.
    exp_beat_t   mon_e;
    logic [63:0] mon_mask;
    always @(negedge clk156) begin
        if (m_axis_tvalid) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                for (int j = 0; j < 8; j++) mon_mask[8*j +: 8] = {8{mon_e.keep[j]}};
                chk("tkeep", 64'(m_axis_tkeep), 64'(mon_e.keep));
                chk("tdata", m_axis_tdata & mon_mask, mon_e.data);
                chk("tlast", 64'(m_axis_tlast), 64'(mon_e.last));
                chk("tuser", 64'(m_axis_tuser), 64'(mon_e.user));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        s_axis_rx_tvalid = 1'b0;
        s_axis_rx_tdata  = '0;
        s_axis_rx_tkeep  = '0;
        s_axis_rx_tlast  = 1'b0;
        s_axis_rx_tuser  = 1'b0;
        repeat (3) @(negedge clk156);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata",  m_axis_tdata, 64'd0);
        chk("rst_tkeep",  64'(m_axis_tkeep), 64'd0);
        chk_counters("rst");
        reset = 1'b0;
        idle(2);

        // 1: matching 60-byte frame, 18-byte incrementing payload
        good_frame(18, 1'b1);
        send(1'b1, 0, -1);
        idle(4);
        chk("t1_beats", 64'(beats_seen), 64'd3);
        chk_counters("t1");

        // 2: wrong port, wrong ethertype, wrong MAC
        build(LOCAL_MAC, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT + 16'd1, 18, 1'b1);
        send(1'b1, 0, -1);
        build(LOCAL_MAC, 16'h86DD, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 18, 1'b1);
        send(1'b1, 0, -1);
        build(48'h020000000001, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 18, 1'b1);
        send(1'b1, 0, -1);
        idle(4);
        chk("t2_beats", 64'(beats_seen), 64'd3);
        chk_counters("t2");

        // 3: broadcast, bad FCS
        build(BCAST, 16'h0800, 8'h45, 8'h11, LOCAL_IP, LOCAL_PORT, 18, 1'b0);
        send(1'b0, 0, -1);
        idle(4);
        chk_counters("t3");

        // 4: last beat keep 03 (no flush), then back-to-back frame
        good_frame(16, 1'b0);
        send(1'b1, 0, -1);
        good_frame(30, 1'b0);
        send(1'b1, 0, -1);
        idle(4);
        chk_counters("t4");

        // 5: reset mid-frame on beat 3, rest of frame ignored
        good_frame(40, 1'b0);
        send(1'b1, 0, 3);
        idle(1);
        chk("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk_counters("t5_rst");
        good_frame(25, 1'b0);
        send(1'b1, 0, -1);
        idle(4);
        chk_counters("t5");

        // 6: truncated frame ending on beat 2, then a normal one
        good_frame(0, 1'b0);
        while (fr.size() > 20) void'(fr.pop_back());
        send(1'b1, 0, -1);
        idle(2);
        chk_counters("t6_trunc");
        good_frame(9, 1'b0);
        send(1'b1, 0, -1);
        idle(4);
        chk_counters("t6");

        // Randomized frames: field mismatches, lengths, gaps, back-to-back
        for (int f = 0; f < 60; f++) begin
            logic [47:0] dmac;
            logic [31:0] dip;
            int sel;
            sel  = $urandom_range(0, 9);
            dmac = (sel == 0) ? 48'h020000000001 : (sel == 1) ? BCAST : LOCAL_MAC;
            sel  = $urandom_range(0, 11);
            dip  = (sel == 0) ? (LOCAL_IP ^ 32'h1) : (sel == 1) ? (LOCAL_IP ^ 32'h00010000) : LOCAL_IP;
            build(dmac,
                  ($urandom_range(0, 11) == 0) ? 16'h86DD : 16'h0800,
                  ($urandom_range(0, 11) == 0) ? 8'h46 : 8'h45,
                  ($urandom_range(0, 11) == 0) ? 8'h06 : 8'h11,
                  dip,
                  ($urandom_range(0, 11) == 0) ? LOCAL_PORT + 16'd1 : LOCAL_PORT,
                  $urandom_range(0, 120), 1'b0);
            if ($urandom_range(0, 9) == 0) begin
                sel = $urandom_range(17, 48);
                while (fr.size() > sel) void'(fr.pop_back());
            end
            send(1'($urandom_range(0, 4) != 0), 10, -1);
            idle($urandom_range(0, 2));
        end
        idle(10);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk_counters("final");
        chk("invariant", 64'(cnt_rx_frame), 64'(cnt_rx_accept + cnt_rx_drop));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
